axi_llc_tag_bist_checker: RTL and testbench
===========================================

// Module: axi_llc_tag_bist_checker
// PURPOSE
//  Read-response checker between the tag SRAM read port and the tag BIST pattern generator.
//  Pipelines the expected pattern of every BIST read to match SRAM read latency.
//  Compares it per way against SRAM read data.
//  Returns per-way pass/fail plus an in-flight valid, so the generator can drain reads before switching phase.
// PARAMETERS
//  Cfg          axi_llc_pkg::llc_cfg_t'{default:'0}  static LLC config; uses SetAssociativity
//  pattern_t    logic   tag pattern type {val, dit, tag}; compared as full vector
//  way_ind_t    logic   per-way indicator, bit w = way w, width Cfg.SetAssociativity
//  RdLatency    1       tag SRAM read latency in cycles, req to rdata; legal >= 1
//  ErrCntWidth  8       width of each per-way error counter (optional feature only)
// PORTS
//  clk_i              in   1            clock, rising edge
//  rst_i              in   1            reset, asynchronous, active-high
//  req_i              in   1            BIST SRAM request (same cycle as SRAM req)
//  we_i               in   1            BIST write enable; writes are not checked
//  pattern_i          in   $bits(pattern_t)                 expected pattern for this access
//  sram_rdata_i       in   SetAssociativity*$bits(pattern_t) per-way read data, pattern_t [Assoc-1:0]
//  bist_res_o         out  way_ind_t    per-way result, 1 = match/pass
//  bist_res_valid_o   out  1            read in flight or result presented
//  clr_cnt_i          in   1            synchronous clear of error counters
//  err_cnt_o          out  Assoc*ErrCntWidth  per-way error counters
// BEHAVIOUR
//  - Delay line: RdLatency stages of {vld, exp}; shifts every cycle, no backpressure.
//    Stage 0 loads vld = req_i & ~we_i, exp = pattern_i.
//  - Output stage (stage RdLatency-1) aligns with sram_rdata_i.
//    Result is combinational: bist_res_o[w] = (sram_rdata_i[w] == exp) when out-stage vld, else '1.
//  - bist_res_valid_o = OR of all stage vld bits.
//    Asserted from the cycle after a read req until its result cycle inclusive.
//    Pending stages report '1 (pass), so only real mismatches register as errors.
//  - Latency: result for a read issued in cycle T appears in cycle T+RdLatency.
//    bist_res_valid_o deasserts at T+RdLatency+1 if no later read.
//  - Back-to-back reads: one result per cycle, order preserved.
//    Write cycles insert bubbles (vld=0).
//  - req_i & we_i: nothing pushed; SRAM output in the matching cycle is ignored.
//  - Reset (async, any time incl. mid-BIST): all vld and exp cleared.
//    bist_res_o='1, bist_res_valid_o=0, err_cnt_o='0. In-flight reads are dropped.
//  - No state machine: pure pipeline plus optional counters. Sequential state is vld/exp registers.
// CONFIGURATION
//  AXI_LLC_TAG_BIST_ERR_CNT_EN defined:
//  - Per-way saturating counter, ErrCntWidth bits.
//  - Increments when out-stage vld & ~bist_res_o[w]; holds at all-ones.
//  - Cleared by clr_cnt_i; clear wins over a simultaneous increment.
//  Undefined:
//  - No counter flops; err_cnt_o tied '0; clr_cnt_i ignored. Ports are kept, so the interface is identical.
// STRUCTURE
//  - axi_llc_pkg: none new; reuse llc_cfg_t.
//  - Local typedef bist_stage_t {logic vld; pattern_t exp;}.
//  - Sub-module axi_llc_tag_bist_way_chk, one per way (generate): equality compare plus optional counter.
//  - Elaboration assertion: RdLatency >= 1.
// TESTING
//  1. Assoc=4, RdLatency=1; read pattern '0, rdata all ways '0
//     -> T+1: bist_res_valid_o=1, bist_res_o=4'b1111; T+2: valid=0.
//  2. Same; way 2 rdata bit0=1
//     -> T+1: bist_res_o=4'b1011; with _EN, err_cnt_o[2]=1 at T+2.
//  3. RdLatency=3; 5 back-to-back reads, way 0 mismatch on 3rd
//     -> valid high T+1..T+7; bist_res_o=4'b1110 only at T+5.
//  4. Interleave write (we_i=1, bad rdata) between reads
//     -> no mismatch reported for the write slot; valid gap = 1 cycle when RdLatency=1.
//  5. rst_i asserted with 2 reads in flight (RdLatency=3)
//     -> valid=0, bist_res_o='1 immediately (async); no result after release.
//  6. _EN, ErrCntWidth=2; 5 mismatches on way 1
//     -> err_cnt_o[1]=3 (saturated); clr_cnt_i with mismatch same cycle -> 0.

Source files
------------

// File: rtl/axi_llc_pkg.sv
// axi_llc_pkg: shared static LLC configuration type
package axi_llc_pkg;
  typedef struct packed {
    int unsigned SetAssociativity;
    int unsigned NumLines;
    int unsigned NumBlocks;
  } llc_cfg_t;
endpackage

// File: rtl/axi_llc_tag_bist_checker_way_chk.sv
// axi_llc_tag_bist_way_chk: one-way tag compare; saturating error counter when AXI_LLC_TAG_BIST_ERR_CNT_EN is defined
module axi_llc_tag_bist_way_chk #(
  parameter int unsigned PatWidth    = 1,
  parameter int unsigned ErrCntWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   vld_i,
  input  logic [PatWidth-1:0]    exp_i,
  input  logic [PatWidth-1:0]    rdata_i,
  input  logic                   clr_cnt_i,
  output logic                   res_o,
  output logic [ErrCntWidth-1:0] err_cnt_o
);
  assign res_o = ~vld_i | (rdata_i == exp_i);
`ifdef AXI_LLC_TAG_BIST_ERR_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) err_cnt_o <= '0;
    else if (clr_cnt_i) err_cnt_o <= '0;
    else if (~res_o && ~&err_cnt_o) err_cnt_o <= err_cnt_o + 1'b1;
`else
  logic unused;
  assign unused    = ^{clk_i, rst_i, clr_cnt_i};
  assign err_cnt_o = '0;
`endif
endmodule

// File: rtl/axi_llc_tag_bist_checker.sv
// axi_llc_tag_bist_checker: delays BIST expected tags by the SRAM read latency and checks every way; counters via AXI_LLC_TAG_BIST_ERR_CNT_EN
module axi_llc_tag_bist_checker
  import axi_llc_pkg::*;
#(
  parameter llc_cfg_t    Cfg         = llc_cfg_t'{default: '0},
  parameter type         pattern_t   = logic,
  parameter type         way_ind_t   = logic,
  parameter int unsigned RdLatency   = 1,
  parameter int unsigned ErrCntWidth = 8
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         req_i,
  input  logic                                         we_i,
  input  logic [$bits(pattern_t)-1:0]                  pattern_i,
  input  logic [Cfg.SetAssociativity*$bits(pattern_t)-1:0] sram_rdata_i,
  output way_ind_t                                     bist_res_o,
  output logic                                         bist_res_valid_o,
  input  logic                                         clr_cnt_i,
  output logic [Cfg.SetAssociativity*ErrCntWidth-1:0]  err_cnt_o
);
  localparam int unsigned Assoc = Cfg.SetAssociativity;
  localparam int unsigned PW    = $bits(pattern_t);
  typedef struct packed {
    logic     vld;
    pattern_t exp;
  } bist_stage_t;
  if (RdLatency < 1) begin : g_bad_latency
    $error("axi_llc_tag_bist_checker: RdLatency must be >= 1");
  end
  bist_stage_t [RdLatency-1:0] stage_q;
  bist_stage_t                 out;
  // writes enter as bubbles so their SRAM output slot is never judged
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) stage_q <= '0;
    else begin
      stage_q[0] <= '{vld: req_i & ~we_i, exp: pattern_i};
      for (int i = 1; i < int'(RdLatency); i++) stage_q[i] <= stage_q[i-1];
    end
  assign out = stage_q[RdLatency-1];
  always_comb begin
    bist_res_valid_o = 1'b0;
    for (int i = 0; i < int'(RdLatency); i++) bist_res_valid_o |= stage_q[i].vld;
  end
  for (genvar w = 0; w < Assoc; w++) begin : g_way
    axi_llc_tag_bist_way_chk #(
      .PatWidth   (PW),
      .ErrCntWidth(ErrCntWidth)
    ) i_chk (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .vld_i    (out.vld),
      .exp_i    (out.exp),
      .rdata_i  (sram_rdata_i[w*PW +: PW]),
      .clr_cnt_i(clr_cnt_i),
      .res_o    (bist_res_o[w]),
      .err_cnt_o(err_cnt_o[w*ErrCntWidth +: ErrCntWidth])
    );
  end
endmodule

// File: tb/tb_axi_llc_tag_bist_checker.sv
// tb_axi_llc_tag_bist_checker: scoreboard bench driving a RdLatency=1 and a RdLatency=3 instance in lockstep
module tb_axi_llc_tag_bist_checker;
  import axi_llc_pkg::*;
  typedef struct packed {logic val; logic dit; logic [5:0] tag;} tb_pattern_t;
  typedef struct packed {logic vld; logic [3:0] exp_res; logic [31:0] rdata;} ent_t;
  localparam llc_cfg_t Cfg = llc_cfg_t'{SetAssociativity: 32'd4, default: '0};
  localparam int Lat [2] = '{1, 3};
  localparam int Cw  [2] = '{2, 8};
`ifdef AXI_LLC_TAG_BIST_ERR_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif
  logic        clk_i = 1'b0;
  logic        rst_i, req_i, we_i, clr_cnt_i;
  logic [7:0]  pattern_i;
  logic [31:0] rdata [2];
  logic [3:0]  res [2];
  logic        vld [2];
  logic [7:0]  cnt0;
  logic [31:0] cnt1;
  ent_t        sb [2][$];
  int          cm [2][4];
  int          n_chk = 0, n_fail = 0;

  always #5 clk_i = ~clk_i;

  axi_llc_tag_bist_checker #(
    .Cfg(Cfg), .pattern_t(tb_pattern_t), .way_ind_t(logic [3:0]), .RdLatency(1), .ErrCntWidth(2)
  ) dut_l1 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .pattern_i(pattern_i),
    .sram_rdata_i(rdata[0]), .bist_res_o(res[0]), .bist_res_valid_o(vld[0]),
    .clr_cnt_i(clr_cnt_i), .err_cnt_o(cnt0)
  );

  axi_llc_tag_bist_checker #(
    .Cfg(Cfg), .pattern_t(tb_pattern_t), .way_ind_t(logic [3:0]), .RdLatency(3), .ErrCntWidth(8)
  ) dut_l3 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .pattern_i(pattern_i),
    .sram_rdata_i(rdata[1]), .bist_res_o(res[1]), .bist_res_valid_o(vld[1]),
    .clr_cnt_i(clr_cnt_i), .err_cnt_o(cnt1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_rdata(input logic [7:0] p, input logic [3:0] b);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = p ^ {7'd0, b[k]};
    return r;
  endfunction

  function automatic logic [31:0] exp_cnt(input int d);
    logic [31:0] v = '0;
    for (int k = 0; k < 4; k++) v |= 32'(cm[d][k]) << (k * Cw[d]);
    return CntEn ? v : 32'd0;
  endfunction

  function automatic logic [31:0] act_cnt(input int d);
    return d == 0 ? {24'd0, cnt0} : cnt1;
  endfunction

  task automatic reset_models();
    for (int d = 0; d < 2; d++) begin
      sb[d].delete();
      for (int i = 0; i < Lat[d]; i++) sb[d].push_back(ent_t'{vld: 1'b0, exp_res: 4'hf, rdata: $urandom});
      for (int k = 0; k < 4; k++) cm[d][k] = 0;
    end
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_res%0d", tag, d), 32'(res[d]), 32'hf);
      check($sformatf("%s_vld%0d", tag, d), 32'(vld[d]), 32'd0);
      check($sformatf("%s_cnt%0d", tag, d), act_cnt(d), 32'd0);
    end
  endtask

  task automatic step(input logic rq, input logic wr, input logic [7:0] p, input logic [3:0] b, input logic c);
    ent_t h [2];
    logic ev [2];
    for (int d = 0; d < 2; d++) begin
      h[d]  = sb[d][0];
      ev[d] = 1'b0;
      for (int i = 0; i < sb[d].size(); i++) ev[d] |= sb[d][i].vld;
    end
    req_i = rq; we_i = wr; pattern_i = p; clr_cnt_i = c;
    rdata[0] = h[0].rdata;
    rdata[1] = h[1].rdata;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("res_l%0d", Lat[d]), 32'(res[d]), 32'(h[d].exp_res));
      check($sformatf("vld_l%0d", Lat[d]), 32'(vld[d]), 32'(ev[d]));
      check($sformatf("cnt_l%0d", Lat[d]), act_cnt(d), exp_cnt(d));
      for (int k = 0; k < 4; k++)
        if (c) cm[d][k] = 0;
        else if (h[d].vld && !h[d].exp_res[k] && cm[d][k] != (1 << Cw[d]) - 1) cm[d][k]++;
      sb[d].pop_front();
      sb[d].push_back(ent_t'{vld: rq & ~wr, exp_res: (rq & ~wr) ? ~b : 4'hf, rdata: mk_rdata(p, b)});
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; clr_cnt_i = 1'b0; pattern_i = '0;
    rdata[0] = '0; rdata[1] = '0;
    #3;
    check_idle("reset");
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    reset_models();
    @(posedge clk_i);
    #1;
    // single clean read, then single read with way 2 mismatch
    step(1'b1, 1'b0, 8'h00, 4'h0, 1'b0);
    repeat (3) idle();
    step(1'b1, 1'b0, 8'h00, 4'b0100, 1'b0);
    repeat (3) idle();
    // five back-to-back reads, way 0 mismatch on the third
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), i == 2 ? 4'b0001 : 4'h0, 1'b0);
    repeat (4) idle();
    // write with bad rdata between reads
    step(1'b1, 1'b0, 8'h3c, 4'h0, 1'b0);
    step(1'b1, 1'b1, 8'h55, 4'hf, 1'b0);
    step(1'b1, 1'b0, 8'h5a, 4'h0, 1'b0);
    repeat (4) idle();
    // counter saturation on way 1, then clear coinciding with a mismatch
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'($urandom), 4'b0010, 1'b0);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
    repeat (4) idle();
    // async reset with failing reads in flight
    step(1'b1, 1'b0, 8'h11, 4'hf, 1'b0);
    step(1'b1, 1'b0, 8'h22, 4'hf, 1'b0);
    req_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check_idle("rst_async");
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    reset_models();
    @(posedge clk_i);
    #1;
    repeat (5) idle();
    for (int i = 0; i < 80; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 8'($urandom),
           $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'h0, $urandom_range(0, 15) == 0);
    repeat (4) idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
